// File: rtl/cpu_pkg.sv
`default_nettype none
// =============================================================================
// Module : cpu_pkg
// Brief  : Shared data-memory widths and request record for the CPU core.
// Rev    : 1.0
// =============================================================================
package cpu_pkg;

   localparam int MEM_ADDR_WIDTH = 16;
   localparam int MEM_DATA_WIDTH = 32;

   typedef struct packed {
      logic                      we;
      logic [MEM_ADDR_WIDTH-1:0] addr;
      logic [MEM_DATA_WIDTH-1:0] wdata;
   } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// =============================================================================
// Module : dmem_arbiter
// Brief  : Two-requester DMEM arbiter (MA stage vs DMA/debug), RR or fixed.
// Rev    : 1.0
// =============================================================================
module dmem_arbiter
   import cpu_pkg::*;
#(
   parameter int RR_MODE      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      R0_Valid,
   output logic                      R0_Ready,
   input  logic                      R0_We,
   input  logic [MEM_ADDR_WIDTH-1:0] R0_Addr,
   input  logic [MEM_DATA_WIDTH-1:0] R0_Wdata,
   output logic                      R0_Rvalid,
   output logic [MEM_DATA_WIDTH-1:0] R0_Rdata,
   input  logic                      R1_Valid,
   output logic                      R1_Ready,
   input  logic                      R1_We,
   input  logic [MEM_ADDR_WIDTH-1:0] R1_Addr,
   input  logic [MEM_DATA_WIDTH-1:0] R1_Wdata,
   output logic                      R1_Rvalid,
   output logic [MEM_DATA_WIDTH-1:0] R1_Rdata,
   output logic [MEM_ADDR_WIDTH-1:0] Dmem_Addr,
   output logic [MEM_DATA_WIDTH-1:0] Dmem_Wdata,
   output logic                      Dmem_Wen,
   output logic                      Dmem_Ren,
   input  logic [MEM_DATA_WIDTH-1:0] Dmem_Rdata,
   output logic [15:0]               Grant_Cnt0,
   output logic [15:0]               Grant_Cnt1
);

   localparam logic [3:0]  c_starve_limit = 4'(STARVE_LIMIT);
   localparam logic [15:0] c_cnt_max      = 16'hFFFF;

   logic        last_q;
   logic [3:0]  starve_q;
   logic        rd_pend_q;
   logic        rd_tag_q;
   logic [15:0] r_cnt0;
   logic [15:0] r_cnt1;

   logic        w_v0;
   logic        w_v1;
   logic        w_pick1;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_any;
   dmem_req_t   w_sel;

   // Returns 1 when requester 1 should win; on contention the one not granted last wins.
   function automatic logic rr_pick(input logic last, input logic v0, input logic v1);
      if (v0 && v1) return ~last;
      return v1 && !v0;
   endfunction

   always_comb begin
      w_v0    = R0_Valid && !Rst;
      w_v1    = R1_Valid && !Rst;
      w_pick1 = 1'b0;
      if (RR_MODE != 0)
         w_pick1 = rr_pick(last_q, w_v0, w_v1);
      else
         w_pick1 = w_v1 && (!w_v0 || (starve_q == c_starve_limit));
      w_gnt1 = w_v1 && w_pick1;
      w_gnt0 = w_v0 && !w_gnt1;
      w_any  = w_gnt0 || w_gnt1;

      w_sel = '0;
      if (w_gnt1)
         w_sel = '{we: R1_We, addr: R1_Addr, wdata: R1_Wdata};
      else if (w_gnt0)
         w_sel = '{we: R0_We, addr: R0_Addr, wdata: R0_Wdata};
   end

   assign R0_Ready   = w_gnt0;
   assign R1_Ready   = w_gnt1;
   assign Dmem_Addr  = w_sel.addr;
   assign Dmem_Wdata = w_sel.wdata;
   assign Dmem_Wen   = w_any && w_sel.we;
   assign Dmem_Ren   = w_any && !w_sel.we;

   // Read data is steered to whichever requester owned last cycle's read grant.
   assign R0_Rvalid  = rd_pend_q && !rd_tag_q;
   assign R1_Rvalid  = rd_pend_q && rd_tag_q;
   assign R0_Rdata   = R0_Rvalid ? Dmem_Rdata : '0;
   assign R1_Rdata   = R1_Rvalid ? Dmem_Rdata : '0;
   assign Grant_Cnt0 = r_cnt0;
   assign Grant_Cnt1 = r_cnt1;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         last_q    <= 1'b1;
         starve_q  <= 4'd0;
         rd_pend_q <= 1'b0;
         rd_tag_q  <= 1'b0;
         r_cnt0    <= 16'd0;
         r_cnt1    <= 16'd0;
      end else begin
         if (w_any)
            last_q <= w_gnt1;

         if (w_gnt1)
            starve_q <= 4'd0;
         else if (w_v1)
            starve_q <= starve_q + 4'd1;

         rd_pend_q <= w_any && !w_sel.we;
         if (w_any && !w_sel.we)
            rd_tag_q <= w_gnt1;

         if (w_gnt0 && (r_cnt0 != c_cnt_max))
            r_cnt0 <= r_cnt0 + 16'd1;
         if (w_gnt1 && (r_cnt1 != c_cnt_max))
            r_cnt1 <= r_cnt1 + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// =============================================================================
// Module : tb_dmem_arbiter
// Brief  : Directed self-checking bench for dmem_arbiter (RR and fixed modes).
// Rev    : 1.0
// =============================================================================
module tb_dmem_arbiter;
   import cpu_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   // Round-robin instance with a small synchronous memory model
   logic                      r0_valid, r0_ready, r0_we, r0_rvalid;
   logic [MEM_ADDR_WIDTH-1:0] r0_addr;
   logic [MEM_DATA_WIDTH-1:0] r0_wdata, r0_rdata;
   logic                      r1_valid, r1_ready, r1_we, r1_rvalid;
   logic [MEM_ADDR_WIDTH-1:0] r1_addr;
   logic [MEM_DATA_WIDTH-1:0] r1_wdata, r1_rdata;
   logic [MEM_ADDR_WIDTH-1:0] dmem_addr;
   logic [MEM_DATA_WIDTH-1:0] dmem_wdata, dmem_rdata;
   logic                      dmem_wen, dmem_ren;
   logic [15:0]               cnt0, cnt1;
   logic [MEM_DATA_WIDTH-1:0] mem [0:255];

   // Fixed-priority instance
   logic                      f0_valid, f0_ready, f0_rvalid;
   logic [MEM_DATA_WIDTH-1:0] f0_rdata;
   logic                      f1_valid, f1_ready, f1_rvalid;
   logic [MEM_DATA_WIDTH-1:0] f1_rdata;
   logic [MEM_ADDR_WIDTH-1:0] f_dmem_addr;
   logic [MEM_DATA_WIDTH-1:0] f_dmem_wdata;
   logic                      f_dmem_wen, f_dmem_ren;
   logic [15:0]               fcnt0, fcnt1;

   dmem_arbiter #(.RR_MODE(1), .STARVE_LIMIT(4)) u_rr (
      .Clk(clk), .Rst(rst),
      .R0_Valid(r0_valid), .R0_Ready(r0_ready), .R0_We(r0_we), .R0_Addr(r0_addr),
      .R0_Wdata(r0_wdata), .R0_Rvalid(r0_rvalid), .R0_Rdata(r0_rdata),
      .R1_Valid(r1_valid), .R1_Ready(r1_ready), .R1_We(r1_we), .R1_Addr(r1_addr),
      .R1_Wdata(r1_wdata), .R1_Rvalid(r1_rvalid), .R1_Rdata(r1_rdata),
      .Dmem_Addr(dmem_addr), .Dmem_Wdata(dmem_wdata), .Dmem_Wen(dmem_wen),
      .Dmem_Ren(dmem_ren), .Dmem_Rdata(dmem_rdata),
      .Grant_Cnt0(cnt0), .Grant_Cnt1(cnt1)
   );

   dmem_arbiter #(.RR_MODE(0), .STARVE_LIMIT(4)) u_fx (
      .Clk(clk), .Rst(rst),
      .R0_Valid(f0_valid), .R0_Ready(f0_ready), .R0_We(1'b0), .R0_Addr(16'h0001),
      .R0_Wdata(32'd0), .R0_Rvalid(f0_rvalid), .R0_Rdata(f0_rdata),
      .R1_Valid(f1_valid), .R1_Ready(f1_ready), .R1_We(1'b0), .R1_Addr(16'h0002),
      .R1_Wdata(32'd0), .R1_Rvalid(f1_rvalid), .R1_Rdata(f1_rdata),
      .Dmem_Addr(f_dmem_addr), .Dmem_Wdata(f_dmem_wdata), .Dmem_Wen(f_dmem_wen),
      .Dmem_Ren(f_dmem_ren), .Dmem_Rdata(32'd0),
      .Grant_Cnt0(fcnt0), .Grant_Cnt1(fcnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dmem_ren) dmem_rdata <= mem[dmem_addr[7:0]];
      if (dmem_wen) mem[dmem_addr[7:0]] <= dmem_wdata;
   end

   task automatic idle_all();
      r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
      f0_valid = 1'b0; f1_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_all();
      r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 16'h0055; r0_wdata = 32'h1234;
      r1_valid = 1'b1;
      f0_valid = 1'b1; f1_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({r0_ready, r1_ready, dmem_wen, dmem_ren, f0_ready, f1_ready} !== 6'b0) begin
         bad++;
         $display("FAIL reset_strobes got=%b want=000000",
                  {r0_ready, r1_ready, dmem_wen, dmem_ren, f0_ready, f1_ready});
      end
      total++;
      if (dmem_addr !== 16'h0 || dmem_wdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_dmem_bus got addr=%h wdata=%h want 0", dmem_addr, dmem_wdata);
      end
      total++;
      if ({cnt0, cnt1, fcnt0, fcnt1} !== 64'h0 || r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0
          || r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_state got cnt0=%h cnt1=%h rv0=%b rv1=%b want all 0",
                  cnt0, cnt1, r0_rvalid, r1_rvalid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      idle_all();
   endtask

   task automatic test_rr();
      logic [3:0] exp_g1;
      exp_g1 = 4'b1010;  // bit i = requester 1 wins cycle i
      r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 16'h0040;
      r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 16'h0041;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (r0_ready !== !exp_g1[i] || r1_ready !== exp_g1[i]) begin
            bad++;
            $display("FAIL rr_grant[%0d] got r0=%b r1=%b want r0=%b r1=%b",
                     i, r0_ready, r1_ready, !exp_g1[i], exp_g1[i]);
         end
         total++;
         if (dmem_addr !== (exp_g1[i] ? 16'h0041 : 16'h0040)) begin
            bad++;
            $display("FAIL rr_addr[%0d] got=%h want=%h", i, dmem_addr,
                     exp_g1[i] ? 16'h0041 : 16'h0040);
         end
         @(posedge clk); #1;
      end
      idle_all();
      total++;
      if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin
         bad++;
         $display("FAIL rr_counts got cnt0=%0d cnt1=%0d want 2 2", cnt0, cnt1);
      end
      @(negedge clk);
      total++;
      if ({r0_ready, r1_ready, dmem_wen, dmem_ren} !== 4'b0 || dmem_addr !== 16'h0) begin
         bad++;
         $display("FAIL idle_bus got rdy=%b%b wen=%b ren=%b addr=%h want 0",
                  r0_ready, r1_ready, dmem_wen, dmem_ren, dmem_addr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 16'h0010;
      @(negedge clk);
      total++;
      if (r0_ready !== 1'b1 || dmem_ren !== 1'b1 || dmem_wen !== 1'b0 || dmem_addr !== 16'h0010) begin
         bad++;
         $display("FAIL read_issue got rdy=%b ren=%b wen=%b addr=%h want 1 1 0 0010",
                  r0_ready, dmem_ren, dmem_wen, dmem_addr);
      end
      @(posedge clk); #1;
      idle_all();
      @(negedge clk);
      total++;
      if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hDEADBEEF || r1_rvalid !== 1'b0 || r1_rdata !== 32'h0) begin
         bad++;
         $display("FAIL read_resp got rv0=%b rd0=%h rv1=%b rd1=%h want 1 deadbeef 0 0",
                  r0_rvalid, r0_rdata, r1_rvalid, r1_rdata);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (r0_rvalid !== 1'b0 || r0_rdata !== 32'h0) begin
         bad++;
         $display("FAIL read_done got rv0=%b rd0=%h want 0 0", r0_rvalid, r0_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 16'h0020; r1_wdata = 32'h55;
      @(negedge clk);
      total++;
      if (r1_ready !== 1'b1 || dmem_wen !== 1'b1 || dmem_ren !== 1'b0 || dmem_wdata !== 32'h55) begin
         bad++;
         $display("FAIL write_issue got rdy=%b wen=%b ren=%b wdata=%h want 1 1 0 55",
                  r1_ready, dmem_wen, dmem_ren, dmem_wdata);
      end
      @(posedge clk); #1;
      idle_all();
      r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 16'h0020;
      @(negedge clk);
      total++;
      if (r1_rvalid !== 1'b0 || r0_ready !== 1'b1) begin
         bad++;
         $display("FAIL write_no_rvalid got rv1=%b rdy0=%b want 0 1", r1_rvalid, r0_ready);
      end
      @(posedge clk); #1;
      idle_all();
      @(negedge clk);
      total++;
      if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h55) begin
         bad++;
         $display("FAIL write_then_read got rv0=%b rd0=%h want 1 00000055", r0_rvalid, r0_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 16'h0010;
      @(posedge clk); #1;
      idle_all();
      r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 16'h0020;
      @(negedge clk);
      total++;
      if (r1_ready !== 1'b1 || r0_rvalid !== 1'b1 || r0_rdata !== 32'hDEADBEEF || r1_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_first got rdy1=%b rv0=%b rd0=%h rv1=%b want 1 1 deadbeef 0",
                  r1_ready, r0_rvalid, r0_rdata, r1_rvalid);
      end
      @(posedge clk); #1;
      idle_all();
      r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 16'h0030; r0_wdata = 32'h77;
      @(negedge clk);
      total++;
      if (r1_rvalid !== 1'b1 || r1_rdata !== 32'h55 || r0_rvalid !== 1'b0 || r0_rdata !== 32'h0) begin
         bad++;
         $display("FAIL b2b_second got rv1=%b rd1=%h rv0=%b rd0=%h want 1 55 0 0",
                  r1_rvalid, r1_rdata, r0_rvalid, r0_rdata);
      end
      total++;
      if (r0_ready !== 1'b1 || dmem_wen !== 1'b1 || dmem_addr !== 16'h0030) begin
         bad++;
         $display("FAIL b2b_write_overlap got rdy0=%b wen=%b addr=%h want 1 1 0030",
                  r0_ready, dmem_wen, dmem_addr);
      end
      @(posedge clk); #1;
      idle_all();
   endtask

   task automatic test_reset_mid_read();
      r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 16'h0010;
      @(posedge clk); #1;
      idle_all();
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (r0_rvalid !== 1'b0 || r0_rdata !== 32'h0 || cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
         bad++;
         $display("FAIL rst_mid_read got rv0=%b rd0=%h cnt0=%0d cnt1=%0d want 0 0 0 0",
                  r0_rvalid, r0_rdata, cnt0, cnt1);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL rst_release_rvalid got rv0=%b rv1=%b want 0 0", r0_rvalid, r1_rvalid);
      end
      @(posedge clk); #1;
      r0_valid = 1'b1; r1_valid = 1'b1;
      @(negedge clk);
      total++;
      if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_first_contention got r0=%b r1=%b want 1 0", r0_ready, r1_ready);
      end
      @(posedge clk); #1;
      idle_all();
   endtask

   task automatic test_fixed();
      logic [5:0] exp_g1;
      exp_g1 = 6'b010000;  // bit i = requester 1 wins cycle i
      f0_valid = 1'b1; f1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (f0_ready !== !exp_g1[i] || f1_ready !== exp_g1[i]) begin
            bad++;
            $display("FAIL fixed_grant[%0d] got r0=%b r1=%b want r0=%b r1=%b",
                     i, f0_ready, f1_ready, !exp_g1[i], exp_g1[i]);
         end
         @(posedge clk); #1;
      end
      f1_valid = 1'b0;
      total++;
      if (fcnt0 !== 16'd5 || fcnt1 !== 16'd1) begin
         bad++;
         $display("FAIL fixed_counts got cnt0=%0d cnt1=%0d want 5 1", fcnt0, fcnt1);
      end
   endtask

   task automatic test_saturate();
      // requester 0 stays valid and alone; count climbs from 5 to 0xFFFE
      repeat (65529) @(posedge clk);
      #1;
      total++;
      if (fcnt0 !== 16'hFFFE) begin
         bad++;
         $display("FAIL sat_preload got=%h want=fffe", fcnt0);
      end
      @(posedge clk); #1;
      total++;
      if (fcnt0 !== 16'hFFFF) begin
         bad++;
         $display("FAIL sat_reach got=%h want=ffff", fcnt0);
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (fcnt0 !== 16'hFFFF || fcnt1 !== 16'd1) begin
         bad++;
         $display("FAIL sat_hold got cnt0=%h cnt1=%h want ffff 0001", fcnt0, fcnt1);
      end
      idle_all();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      dmem_rdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 32'hDEADBEEF;
      test_reset();
      test_rr();
      test_read();
      test_write_read();
      test_back_to_back();
      test_reset_mid_read();
      test_fixed();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
